// File: rtl/cpu_bus_pkg.sv
// Shared CPU-bus definitions: read-responder states, BRAM select map and helpers.
package cpu_bus_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRIVE, TURN} rd_state_t;

  localparam int BRAM_SEL_NUM = 4;

  localparam logic [1:0] BRAM_SELECT_CONTROLLER = 2'd0;
  localparam logic [1:0] BRAM_SELECT_MOD        = 2'd1;
  localparam logic [1:0] BRAM_SELECT_NORMAL     = 2'd2;
  localparam logic [1:0] BRAM_SELECT_STM        = 2'd3;

  function automatic logic [BRAM_SEL_NUM-1:0] sel_onehot(input logic [1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/cpu_read_responder_rd_latency_counter.sv
// Loadable 3-bit down-counter with zero flag; paces the BRAM read latency.
module rd_latency_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_read_responder.sv
// CPU read responder: edge-detected read -> BRAM read -> drive CPU_DATA with turnaround.
// Optional error counter output ERR_CNT when CPU_RD_ERR_CNT_EN is defined.
module cpu_read_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned                 RD_LATENCY = 2,
  parameter logic [BRAM_SEL_NUM-1:0]     SEL_MASK   = 4'b1111
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           EN,
  input  logic                           RD,
  input  logic                           RDWR,
  input  logic                           WE,
  input  logic [1:0]                     BRAM_SELECT,
  input  logic [13:0]                    BRAM_ADDR,
  input  logic [BRAM_SEL_NUM-1:0][15:0]  RD_DATA,
  output logic [BRAM_SEL_NUM-1:0]        RD_EN,
  output logic [13:0]                    RD_ADDR,
  output logic [15:0]                    DATA_OUT,
  output logic                           DATA_OE,
  output logic                           BUSY
`ifdef CPU_RD_ERR_CNT_EN
  ,
  output logic [15:0]                    ERR_CNT
`endif
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

  rd_state_t                 state_q, state_d;
  logic                      req, req_prev_q, rd_hold, collide, accept;
  logic                      cnt_load, cnt_dec, cnt_zero;
  logic [1:0]                sel_q, sel_d;
  logic [13:0]               rd_addr_q, rd_addr_d;
  logic [BRAM_SEL_NUM-1:0]   rd_en_q, rd_en_d;
  logic [15:0]               data_out_q, data_out_d;
  logic                      data_oe_q, data_oe_d;

  assign req     = EN & RD & RDWR & ~WE;
  assign rd_hold = EN & RD;
  // TURN is already heading to IDLE, so a write there needs no extra action.
  assign collide = WE & (state_q inside {ISSUE, WAIT, DRIVE});
  assign accept  = (state_q == IDLE) & req & ~req_prev_q;
  assign cnt_dec = (state_q == WAIT);

  rd_latency_counter u_lat_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rd_addr_d  = rd_addr_q;
    rd_en_d    = '0;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    cnt_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          sel_d     = BRAM_SELECT;
          rd_addr_d = BRAM_ADDR;
          rd_en_d   = SEL_MASK[BRAM_SELECT] ? sel_onehot(BRAM_SELECT) : '0;
        end
      end
      ISSUE: begin
        if (collide || !rd_hold) begin
          state_d = TURN;
        end else begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (collide || !rd_hold) begin
          state_d = TURN;
        end else if (cnt_zero) begin
          state_d    = DRIVE;
          data_out_d = SEL_MASK[sel_q] ? RD_DATA[sel_q] : '0;
          data_oe_d  = 1'b1;
        end
      end
      DRIVE: begin
        if (collide || !rd_hold) begin
          state_d   = TURN;
          data_oe_d = 1'b0;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      sel_q      <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req;
      sel_q      <= sel_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign RD_EN    = rd_en_q;
  assign RD_ADDR  = rd_addr_q;
  assign DATA_OUT = data_out_q;
  assign DATA_OE  = data_oe_q;
  assign BUSY     = (state_q != IDLE);

`ifdef CPU_RD_ERR_CNT_EN
  logic        err_evt;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Causes are OR-ed so simultaneous events in one cycle count once.
  assign err_evt = (accept & ~SEL_MASK[BRAM_SELECT])
                 | ((state_q inside {ISSUE, WAIT}) & (collide | ~rd_hold))
                 | ((state_q == DRIVE) & collide);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_read_responder.sv
// Randomized bench for cpu_read_responder: two DUT configurations against a latency-level model.
module tb_cpu_read_responder;

  localparam int NDUT = 2;
  localparam int unsigned LAT0  = 2;
  localparam int unsigned LAT1  = 1;
  localparam logic [3:0]  MASK0 = 4'b1111;
  localparam logic [3:0]  MASK1 = 4'b0111;

  logic        clk = 1'b0;
  logic        reset, en, rd, rdwr, we;
  logic [1:0]  sel;
  logic [13:0] addr;

  logic [3:0][15:0] rd_data  [NDUT];
  logic [3:0]       rd_en    [NDUT];
  logic [13:0]      rd_addr  [NDUT];
  logic [15:0]      data_out [NDUT];
  logic             data_oe  [NDUT];
  logic             busy     [NDUT];
`ifdef CPU_RD_ERR_CNT_EN
  logic [15:0]      err_cnt  [NDUT];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_read_responder #(.RD_LATENCY(LAT0), .SEL_MASK(MASK0)) dut0 (
    .CLK(clk), .RESET(reset), .EN(en), .RD(rd), .RDWR(rdwr), .WE(we),
    .BRAM_SELECT(sel), .BRAM_ADDR(addr), .RD_DATA(rd_data[0]),
    .RD_EN(rd_en[0]), .RD_ADDR(rd_addr[0]), .DATA_OUT(data_out[0]),
    .DATA_OE(data_oe[0]), .BUSY(busy[0])
`ifdef CPU_RD_ERR_CNT_EN
    , .ERR_CNT(err_cnt[0])
`endif
  );

  cpu_read_responder #(.RD_LATENCY(LAT1), .SEL_MASK(MASK1)) dut1 (
    .CLK(clk), .RESET(reset), .EN(en), .RD(rd), .RDWR(rdwr), .WE(we),
    .BRAM_SELECT(sel), .BRAM_ADDR(addr), .RD_DATA(rd_data[1]),
    .RD_EN(rd_en[1]), .RD_ADDR(rd_addr[1]), .DATA_OUT(data_out[1]),
    .DATA_OE(data_oe[1]), .BUSY(busy[1])
`ifdef CPU_RD_ERR_CNT_EN
    , .ERR_CNT(err_cnt[1])
`endif
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic logic [3:0] mask_of(input int d);
    return (d == 0) ? MASK0 : MASK1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // BRAM contents and per-DUT read pipelines of exactly RD_LATENCY stages.
  logic [15:0] mem  [4][16384];
  logic [15:0] pipe [NDUT][4][8];

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      for (int s = 0; s < 4; s++) begin
        for (int k = 7; k > 0; k--) pipe[d][s][k] <= pipe[d][s][k-1];
        pipe[d][s][0] <= rd_en[d][s] ? mem[s][rd_addr[d]] : 16'($urandom);
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NDUT; d++)
      for (int s = 0; s < 4; s++)
        rd_data[d][s] = pipe[d][s][lat_of(d) - 1];
  end

  // Reference model: tracks a read by edges elapsed since acceptance.
  bit          m_prev;
  bit          m_busy [NDUT], m_inflight [NDUT], m_drive [NDUT], m_turn [NDUT];
  int          m_age  [NDUT];
  logic [1:0]  m_sel  [NDUT];
  logic [13:0] m_addr [NDUT];
  logic [15:0] m_dout [NDUT];
  logic [3:0]  m_rden [NDUT];
  int unsigned m_err  [NDUT];

  always @(posedge clk) begin
    bit req, hold, err;
    logic [3:0] msk;
    req  = en & rd & rdwr & ~we;
    hold = en & rd;
    for (int d = 0; d < NDUT; d++) begin
      err = 1'b0;
      msk = mask_of(d);
      m_rden[d] = '0;
      if (reset) begin
        m_busy[d] = 0; m_inflight[d] = 0; m_drive[d] = 0; m_turn[d] = 0;
        m_addr[d] = '0; m_dout[d] = '0; m_err[d] = 0;
      end else if (!m_busy[d]) begin
        if (req && !m_prev) begin
          m_busy[d] = 1; m_inflight[d] = 1; m_age[d] = 1;
          m_sel[d] = sel; m_addr[d] = addr;
          if (msk[sel]) m_rden[d] = 4'b0001 << sel;
          else err = 1'b1;
        end
      end else if (m_turn[d]) begin
        m_turn[d] = 0; m_busy[d] = 0;
      end else if (we || !hold) begin
        err = we || m_inflight[d];
        m_turn[d] = 1; m_inflight[d] = 0; m_drive[d] = 0;
      end else if (m_inflight[d]) begin
        m_age[d]++;
        if (m_age[d] == lat_of(d) + 2) begin
          m_inflight[d] = 0; m_drive[d] = 1;
          m_dout[d] = msk[m_sel[d]] ? mem[m_sel[d]][m_addr[d]] : 16'h0000;
        end
      end
      if (err && m_err[d] < 32'hFFFF) m_err[d]++;
    end
    m_prev = reset ? 1'b0 : req;
  end

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      check_val($sformatf("d%0d_busy", d),     32'(busy[d]),     32'(m_busy[d]));
      check_val($sformatf("d%0d_data_oe", d),  32'(data_oe[d]),  32'(m_drive[d]));
      check_val($sformatf("d%0d_data_out", d), 32'(data_out[d]), 32'(m_dout[d]));
      check_val($sformatf("d%0d_rd_en", d),    32'(rd_en[d]),    32'(m_rden[d]));
      check_val($sformatf("d%0d_rd_addr", d),  32'(rd_addr[d]),  32'(m_addr[d]));
`ifdef CPU_RD_ERR_CNT_EN
      check_val($sformatf("d%0d_err_cnt", d),  32'(err_cnt[d]),  32'(m_err[d]));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic r, input logic w);
    en = e; rd = r; rdwr = 1'b1; we = w;
  endtask

  task automatic idle_gap(input int n);
    drive(1'b0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1; en = 0; rd = 0; rdwr = 0; we = 0; sel = '0; addr = '0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16384; a++) mem[s][a] = 16'($urandom);
    mem[2][5] = 16'hA5C3;
    repeat (3) step();
    check_val("reset_oe", 32'(data_oe[0]), 32'd0);
    check_val("reset_busy", 32'(busy[0]), 32'd0);
    reset = 1'b0;
    idle_gap(2);

    // Basic read, select 2, address 5.
    sel = 2'd2; addr = 14'h0005; drive(1, 1, 0);
    step();
    check_val("t1_rd_en", 32'(rd_en[0]), 32'h4);
    check_val("t1_rd_addr", 32'(rd_addr[0]), 32'h5);
    step();
    check_val("t1_rd_en_pulse", 32'(rd_en[0]), 32'h0);
    step();
    check_val("t1_oe_early", 32'(data_oe[0]), 32'd0);
    check_val("t1_l1_oe", 32'(data_oe[1]), 32'd1);
    check_val("t1_l1_dout", 32'(data_out[1]), 32'hA5C3);
    step();
    check_val("t1_oe", 32'(data_oe[0]), 32'd1);
    check_val("t1_dout", 32'(data_out[0]), 32'hA5C3);
    step(); step();
    rd = 1'b0;
    step();
    check_val("t1_oe_fall", 32'(data_oe[0]), 32'd0);
    check_val("t1_turn_busy", 32'(busy[0]), 32'd1);
    step();
    check_val("t1_idle", 32'(busy[0]), 32'd0);
    idle_gap(2);

    // Unmapped select 3 on the masked instance.
    sel = 2'd3; addr = 14'h0123; drive(1, 1, 0);
    repeat (7) step();
    idle_gap(3);

    // Abort during WAIT.
    sel = 2'd1; drive(1, 1, 0);
    step(); step();
    rd = 1'b0;
    repeat (4) step();
    idle_gap(2);

    // Write collision while driving.
    sel = 2'd0; drive(1, 1, 0);
    repeat (6) step();
    we = 1'b1; step();
    we = 1'b0; repeat (3) step();
    idle_gap(2);

    // Back-to-back reads with 1- and 2-cycle RD gaps.
    sel = 2'd2; drive(1, 1, 0);
    repeat (6) step();
    rd = 1'b0; step();
    rd = 1'b1; repeat (6) step();
    rd = 1'b0; step(); step();
    rd = 1'b1; repeat (8) step();
    idle_gap(3);

    // Reset while driving.
    sel = 2'd2; addr = 14'h0005; drive(1, 1, 0);
    repeat (5) step();
    reset = 1'b1; step();
    check_val("rst_oe", 32'(data_oe[0]), 32'd0);
    check_val("rst_dout", 32'(data_out[0]), 32'd0);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    reset = 1'b0;
    idle_gap(3);

    // Randomized bursts.
    repeat (500) begin
      int len, gap;
      len = int'($urandom_range(1, 10));
      gap = int'($urandom_range(0, 3));
      idle_gap(gap);
      repeat (len) begin
        en    = ($urandom_range(0, 15) != 0);
        rd    = 1'b1;
        rdwr  = ($urandom_range(0, 15) != 0);
        we    = ($urandom_range(0, 19) == 0);
        sel   = 2'($urandom);
        addr  = 14'($urandom);
        reset = ($urandom_range(0, 199) == 0);
        step();
      end
      reset = 1'b0;
    end
    idle_gap(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
